// File: rtl/simon_pkt_rx.sv
// Byte-serial packet receiver feeding SIMON_dataIN: assembles info/count/payload
// bytes into a one-packet buffer and presents it with the newPKT/loadPKT/donePKT handshake.
module simon_pkt_rx #(
    parameter int N = 32
) (
    input  logic                  clk,
    input  logic                  nR,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [(1+N/2):0][7:0] in,
    output logic                  in_newPKT,
    input  logic                  in_loadPKT,
    input  logic                  in_donePKT,
    output logic [7:0]            pkt_cnt,
    output logic                  seq_err
);
    localparam int P  = N/2 + 2;
    localparam int BW = $clog2(P);
    localparam logic [BW-1:0] LAST = BW'(P-1);

    typedef enum logic [1:0] {EMPTY, PRESENT, WAIT_DONE} state_t;

    state_t            state_q;
    logic [P-1:0][7:0] asm_q;
    logic [P-1:0][7:0] in_q;
    logic [BW-1:0]     bidx_q, bidx_d;
    logic              asm_full_q;
    logic              new_q;
    logic              seq_err_q;
    logic [7:0]        pkt_cnt_q, exp_cnt_q;
    logic              accept, xfer;

    assign accept = rx_valid && !asm_full_q;
    assign xfer   = (state_q == EMPTY) && asm_full_q;
    assign bidx_d = (bidx_q == LAST) ? '0 : bidx_q + 1'b1;

    assign rx_ready  = !asm_full_q;
    assign in        = in_q;
    assign in_newPKT = new_q;
    assign pkt_cnt   = pkt_cnt_q;
    assign seq_err   = seq_err_q;

    // First byte lands in the top slot so the buffer reads info, count, payload MSB-first.
    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            asm_q      <= '0;
            bidx_q     <= '0;
            asm_full_q <= 1'b0;
        end else begin
            if (accept) begin
                asm_q[LAST - bidx_q] <= rx_byte;
                bidx_q               <= bidx_d;
                if (bidx_q == LAST)
                    asm_full_q <= 1'b1;
            end else if (xfer) begin
                asm_full_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            state_q   <= EMPTY;
            in_q      <= '0;
            new_q     <= 1'b0;
            pkt_cnt_q <= '0;
            seq_err_q <= 1'b0;
            exp_cnt_q <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (asm_full_q) begin
                        in_q      <= asm_q;
                        state_q   <= PRESENT;
                        new_q     <= 1'b1;
                        pkt_cnt_q <= pkt_cnt_q + 8'd1;
                        if (asm_q[N/2] != exp_cnt_q)
                            seq_err_q <= 1'b1;
                        // Resync to the received count so a single gap flags once.
                        exp_cnt_q <= asm_q[N/2] + 8'd1;
                    end
                end
                PRESENT: begin
                    if (in_loadPKT) begin
                        state_q <= WAIT_DONE;
                        new_q   <= 1'b0;
                    end
                end
                WAIT_DONE: begin
                    if (in_donePKT)
                        state_q <= EMPTY;
                end
                default: begin
                    state_q <= EMPTY;
                    new_q   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_simon_pkt_rx.sv
// Self-checking bench for simon_pkt_rx: byte-queue reference model compared every
// cycle, plus directed literal checks for latency, handshake, overlap, seq errors, reset, wrap.
module tb_simon_pkt_rx;
    localparam int N = 32;
    localparam int P = N/2 + 2;
    localparam int W = P*8;
    typedef logic [P-1:0][7:0] pkt_t;

    logic       clk = 1'b0;
    logic       nR = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    pkt_t       in_bus;
    logic       in_newPKT;
    logic       in_loadPKT;
    logic       in_donePKT;
    logic [7:0] pkt_cnt;
    logic       seq_err;

    simon_pkt_rx #(.N(N)) dut (
        .clk       (clk),
        .nR        (nR),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .in        (in_bus),
        .in_newPKT (in_newPKT),
        .in_loadPKT(in_loadPKT),
        .in_donePKT(in_donePKT),
        .pkt_cnt   (pkt_cnt),
        .seq_err   (seq_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    logic [7:0] q[$];
    bit gap_en = 0, auto_hs = 0, man_load = 0, man_done = 0;
    bit r_load = 0, r_done = 0;
    bit acc_flag = 0;

    always_comb in_loadPKT = auto_hs ? r_load : man_load;
    always_comb in_donePKT = auto_hs ? r_done : man_done;

    always @(negedge clk) begin
        r_load = ($urandom_range(0, 2) == 0);
        r_done = ($urandom_range(0, 2) == 0);
    end

    // Byte source: holds a byte until it is taken, optional random idle gaps.
    always @(negedge clk) begin
        if (q.size() == 0) rx_valid = 1'b0;
        else begin
            if (!rx_valid || acc_flag) rx_valid = gap_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            rx_byte = q[0];
        end
    end

    // Reference model: m_asm[k] / m_in[k] hold the k-th byte received (arrival order).
    logic [7:0] m_asm[P];
    logic [7:0] m_in[P];
    int         m_bidx;
    bit         m_full;
    int         m_phase;   // 0 nothing shown, 1 offered, 2 taken and in use
    logic [7:0] m_cnt, m_exp;
    bit         m_err;

    always @(posedge clk or negedge nR) begin : model
        bit take;
        if (!nR) begin
            for (int k = 0; k < P; k++) begin m_asm[k] = '0; m_in[k] = '0; end
            m_bidx = 0; m_full = 0; m_phase = 0; m_cnt = '0; m_exp = '0; m_err = 0;
            acc_flag = 0;
        end else begin
            take = rx_valid && !m_full;
            acc_flag = take;
            if (m_full && m_phase == 0) begin
                for (int k = 0; k < P; k++) m_in[k] = m_asm[k];
                m_full = 0; m_phase = 1; m_cnt = m_cnt + 8'd1;
                if (m_asm[1] != m_exp) m_err = 1;
                m_exp = m_asm[1] + 8'd1;
            end else if (m_phase == 1 && in_loadPKT) m_phase = 2;
            else if (m_phase == 2 && in_donePKT) m_phase = 0;
            if (take) begin
                m_asm[m_bidx] = rx_byte;
                void'(q.pop_front());
                if (m_bidx == P-1) begin m_bidx = 0; m_full = 1; end
                else m_bidx++;
            end
        end
    end

    task automatic chk(input string nm, input logic [W-1:0] a, input logic [W-1:0] e);
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, a, e);
    endtask

    always @(negedge clk) begin : compare
        pkt_t e;
        for (int k = 0; k < P; k++) e[P-1-k] = m_in[k];
        chk("rx_ready",  W'(rx_ready),  W'(!m_full));
        chk("in_newPKT", W'(in_newPKT), W'(m_phase == 1));
        chk("in",        W'(in_bus),    W'(e));
        chk("pkt_cnt",   W'(pkt_cnt),   W'(m_cnt));
        chk("seq_err",   W'(seq_err),   W'(m_err));
    end

    function automatic pkt_t make_pkt(input logic [7:0] info, input logic [7:0] cnt);
        pkt_t p;
        p[P-1] = info;
        p[P-2] = cnt;
        for (int k = 0; k < P-2; k++) p[k] = 8'($urandom);
        return p;
    endfunction

    task automatic push_pkt(input pkt_t p);
        for (int k = 0; k < P; k++) q.push_back(p[P-1-k]);
    endtask

    task automatic wait_empty(input string nm, input int maxc);
        int c = 0;
        do begin @(negedge clk); c++; end while (q.size() != 0 && c < maxc);
        if (q.size() != 0) begin n_chk++; $display("FAIL %s: timeout waiting for bytes to drain", nm); end
    endtask

    task automatic wait_new(input string nm, input int maxc);
        int c = 0;
        do begin @(negedge clk); c++; end while (!in_newPKT && c < maxc);
        if (!in_newPKT) begin n_chk++; $display("FAIL %s: timeout waiting for in_newPKT", nm); end
    endtask

    task automatic finish_pkt();
        man_load = 1; @(negedge clk); man_load = 0;
        man_done = 1; @(negedge clk); man_done = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #2 nR = 0;
        q.delete();
        repeat (2) @(negedge clk);
        @(posedge clk); #2 nR = 1;
    endtask

    initial begin
        pkt_t e1, p, pz;
        int c;
        pz = '0;
        repeat (3) @(negedge clk);
        chk("rst_rx_ready", W'(rx_ready), W'(1'b1));
        chk("rst_newPKT",   W'(in_newPKT), W'(1'b0));
        chk("rst_in",       W'(in_bus), W'(pz));
        chk("rst_pkt_cnt",  W'(pkt_cnt), W'(8'h00));
        @(posedge clk); #2 nR = 1;

        // Single packet, latency 2 edges from last byte
        e1[P-1] = 8'hA5; e1[P-2] = 8'h00;
        for (int i = 0; i < 16; i++) e1[15-i] = 8'(i+1);
        push_pkt(e1);
        wait_empty("pkt1_bytes", 100);
        chk("lat_edge1_newPKT", W'(in_newPKT), W'(1'b0));
        chk("lat_edge1_rx_ready", W'(rx_ready), W'(1'b0));
        @(negedge clk);
        chk("lat_edge2_newPKT", W'(in_newPKT), W'(1'b1));
        chk("pkt1_in", W'(in_bus), W'(e1));
        chk("pkt1_cnt", W'(pkt_cnt), W'(8'h01));
        chk("pkt1_seq_err", W'(seq_err), W'(1'b0));

        // Handshake: done in PRESENT ignored, load falls newPKT next edge
        man_done = 1; @(negedge clk); man_done = 0;
        chk("hs_done_ignored", W'(in_newPKT), W'(1'b1));
        man_load = 1; @(negedge clk); man_load = 0;
        chk("hs_newPKT_fall", W'(in_newPKT), W'(1'b0));
        chk("hs_in_hold", W'(in_bus), W'(e1));

        // Overlap: packet 2 streams while packet 1 is in use
        p = make_pkt(8'h3C, 8'h01);
        push_pkt(p);
        wait_empty("pkt2_bytes", 100);
        chk("ovl_rx_ready_low", W'(rx_ready), W'(1'b0));
        repeat (3) @(negedge clk);
        chk("ovl_rx_ready_held", W'(rx_ready), W'(1'b0));
        chk("ovl_in_still_pkt1", W'(in_bus), W'(e1));
        man_done = 1; @(negedge clk); man_done = 0;
        chk("ovl_edge1_newPKT", W'(in_newPKT), W'(1'b0));
        @(negedge clk);
        chk("ovl_edge2_newPKT", W'(in_newPKT), W'(1'b1));
        chk("ovl_in_pkt2", W'(in_bus), W'(p));
        chk("ovl_rx_ready_back", W'(rx_ready), W'(1'b1));
        chk("ovl_pkt_cnt", W'(pkt_cnt), W'(8'h02));
        finish_pkt();

        // Sequence error with resync
        do_reset();
        push_pkt(make_pkt(8'h11, 8'h00)); wait_new("seq0", 100);
        chk("seq0_err", W'(seq_err), W'(1'b0));
        finish_pkt();
        push_pkt(make_pkt(8'h22, 8'h05)); wait_new("seq5", 100);
        chk("seq5_err_set", W'(seq_err), W'(1'b1));
        finish_pkt();
        push_pkt(make_pkt(8'h33, 8'h06)); wait_new("seq6", 100);
        chk("seq6_err_sticky", W'(seq_err), W'(1'b1));
        chk("seq_pkt_cnt", W'(pkt_cnt), W'(8'h03));
        finish_pkt();

        // Mid-packet reset after 7 bytes
        for (int k = 0; k < 7; k++) q.push_back(8'($urandom));
        wait_empty("mid_bytes", 100);
        @(posedge clk); #2 nR = 0;
        @(negedge clk);
        chk("mid_rst_rx_ready", W'(rx_ready), W'(1'b1));
        chk("mid_rst_newPKT", W'(in_newPKT), W'(1'b0));
        chk("mid_rst_in", W'(in_bus), W'(pz));
        chk("mid_rst_pkt_cnt", W'(pkt_cnt), W'(8'h00));
        chk("mid_rst_seq_err", W'(seq_err), W'(1'b0));
        @(posedge clk); #2 nR = 1;
        p = make_pkt(8'h5A, 8'h00);
        push_pkt(p);
        wait_new("mid_pkt", 100);
        chk("mid_in_clean", W'(in_bus), W'(p));
        chk("mid_pkt_cnt", W'(pkt_cnt), W'(8'h01));
        finish_pkt();

        // Wrap: 256 packets with random gaps and random handshake
        do_reset();
        gap_en = 1; auto_hs = 1;
        for (int i = 0; i < 256; i++) push_pkt(make_pkt(8'($urandom), 8'(i)));
        c = 0;
        do begin @(negedge clk); c++; end while ((q.size() != 0 || m_full) && c < 60000);
        if (q.size() != 0 || m_full) begin n_chk++; $display("FAIL wrap: timeout before all packets presented"); end
        chk("wrap_pkt_cnt", W'(pkt_cnt), W'(8'h00));
        chk("wrap_seq_err", W'(seq_err), W'(1'b0));
        gap_en = 0; auto_hs = 0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/simon_pkt_rx.md
# simon_pkt_rx

Byte-serial packet receiver that sits directly upstream of `SIMON_dataIN`. It collects a byte stream into a complete `(2 + N/2)`-byte packet: info byte, count byte, then payload. It presents the packet on the `in` bus using the `in_newPKT` / `in_loadPKT` / `in_donePKT` handshake. A one-packet assembly buffer lets the next packet stream in while `SIMON_dataIN` is still processing the current one. Packet sequence numbers are checked against an internal expected count.

## Interface
- `N`, default `32` — SIMON word size (from `SIMON_defintions.svh`). Packet length `P = N/2 + 2` bytes.
- `clk`  in  1  — single clock; all state updates on posedge.
- `nR`  in  1  — asynchronous, active-low reset.
- `rx_byte`  in  8  — incoming byte.
- `rx_valid`  in  1  — `rx_byte` is valid this cycle.
- `rx_ready`  out  1  — block can accept a byte. A byte transfers on a posedge where `rx_valid & rx_ready`.
- `in`  out  `[(1+N/2):0][7:0]` — presented packet. `in[1+N/2]` = info, `in[N/2]` = count, `in[N/2-1:0]` = payload.
- `in_newPKT`  out  1  — packet on `in` is valid and awaiting load.
- `in_loadPKT`  in  1  — downstream has latched `in`.
- `in_donePKT`  in  1  — downstream has finished with the packet.
- `pkt_cnt`  out  8  — number of packets presented, mod 256.
- `seq_err`  out  1  — sticky; set when a count byte ≠ expected count.

## Operation
- **Assembly side**
  - Byte index `bidx` runs 0..P-1. The byte taken at `bidx = k` is stored in `asm[P-1-k]`, so the first byte received becomes the info byte (MSB-first order).
  - Accepting byte P-1 sets `asm_full` and resets `bidx` to 0.
  - `rx_ready = !asm_full`, combinational from registered state.
- **Output FSM states:** `EMPTY`, `PRESENT`, `WAIT_DONE`.
  - `EMPTY`: when `asm_full`, do the transfer on that edge:
    - `in <= asm`, clear `asm_full`, go to `PRESENT`.
    - `pkt_cnt` +1 (wraps 255→0).
    - Count check: compare `asm[N/2]` with `exp_cnt`. On mismatch set `seq_err`. In both cases `exp_cnt <= asm[N/2] + 1` (resync).
  - `PRESENT`: `in_newPKT = 1`. When `in_loadPKT` is sampled 1, go to `WAIT_DONE`. `in_donePKT` is ignored in this state.
  - `WAIT_DONE`: `in_newPKT = 0`. When `in_donePKT` is sampled 1, go to `EMPTY`.
- `in` changes only on the transfer edge. It stays stable through `PRESENT` and `WAIT_DONE`, and holds its last value while in `EMPTY`.
- The assembly side keeps accepting bytes in every output state until `asm_full`.
- Simultaneous events: the last byte accepted on the same edge the FSM enters `EMPTY` gives `asm_full = 1` and state `EMPTY`. Transfer happens on the next edge.
- `in_newPKT` is a registered decode of state `PRESENT`.

## Timing
- **Reset values:** `in` = all 0, `in_newPKT` = 0, `rx_ready` = 1, `pkt_cnt` = 0, `seq_err` = 0.
- **Reset internals:** state `EMPTY`, `bidx` = 0, `asm_full` = 0, `exp_cnt` = 0.
- **Latency, empty pipeline:**
  - The last byte is accepted at edge t.
  - `asm_full` is high after t.
  - Transfer occurs at t+1, and `in_newPKT` is high after t+1.
  - Total: 2 edges from last byte to `in_newPKT`.
- **Throughput:** when `asm_full` is set, `rx_ready` drops the cycle after the last byte. It returns to 1 the cycle after the transfer edge.
- **Handshake edges:**
  - `in_newPKT` falls the edge after `in_loadPKT` is sampled high.
  - `in_newPKT` cannot re-rise before an `in_donePKT` sample plus one `EMPTY` cycle.
- **Mid-packet reset:** `nR` low at any time discards the partial packet and the `asm` contents, and returns all outputs to their reset values immediately (asynchronous reset).
- **Back-pressure:** `rx_valid` with `rx_ready = 0` is not consumed. The source must hold the byte.
- **Level inputs:** `in_loadPKT` / `in_donePKT` held high longer than needed cause no extra transitions outside their states.

## Test plan
- **Single packet** (N=32, P=18): reset, stream `0xA5, 0x00, 0x01..0x10` with `rx_valid` continuous.
  - Required: 2 edges after the last byte, `in_newPKT = 1` and `in = {A5, 00, 01..10}` (payload MSB = `0x01`).
  - `pkt_cnt = 1`, `seq_err = 0`.
- **Handshake:** assert `in_loadPKT` 2 cycles after `in_newPKT`.
  - Required: `in_newPKT` falls the next edge.
  - `in` stays unchanged until `in_donePKT`.
  - `in_donePKT` asserted in `PRESENT` is ignored.
- **Overlap:** stream packet 2 (count `0x01`) while packet 1 is in `WAIT_DONE`.
  - Required: `rx_ready = 0` after the 18th byte.
  - On `in_donePKT`, packet 2 appears with `in_newPKT` 2 edges later.
  - `rx_ready` returns to 1.
- **Sequence error:** send counts `0x00`, `0x05`, `0x06`.
  - Required: `seq_err` set at the second transfer and stays set.
  - No error is flagged for `0x06` (resync).
  - `pkt_cnt = 3`.
- **Mid-packet reset:** pulse `nR` low after 7 bytes, then send a full packet.
  - Required: all outputs at reset values while `nR` is low.
  - The new packet is assembled correctly, with no stale bytes.
- **Wrap:** present 256 packets.
  - Required: `pkt_cnt` wraps to `0x00`.
  - `seq_err` stays 0 when counts run `0x00..0xFF`.
